sram_bank: RTL and testbench

Parametrised on-chip SRAM bank for the memory map. It generalises the fixed SRAM 1 block to any base address, size and access latency. It adds a valid/ready request/response handshake, byte-enable writes, configurable wait states and an error response for out-of-range or misaligned accesses. One instance per memory region sits on the core's data/instruction bus. SRAM 1 is the instance BASE_ADDR=32'h2000_0000, SIZE_BYTES=98304.

---
 rtl/sram_bank_if.sv | 23 ++
 rtl/sram_bank.sv | 168 ++++++++++++++++
 tb/tb_sram_bank.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_if.sv
// Request/response bus between a requester and one sram_bank instance.
interface sram_bank_if;
  logic        req_valid;
  logic        req_ready;
  logic        read_write;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  byte_enable;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_error;
  logic [31:0] data_out;

  modport master (
    output req_valid, read_write, address, data_in, byte_enable, resp_ready,
    input  req_ready, resp_valid, resp_error, data_out
  );

  modport slave (
    input  req_valid, read_write, address, data_in, byte_enable, resp_ready,
    output req_ready, resp_valid, resp_error, data_out
  );
endinterface

// File: rtl/sram_bank.sv
// Parametrised word-organised SRAM bank with valid/ready handshake,
// byte-lane writes, programmable wait states and range/alignment error response.
//
// state  | meaning
// S_IDLE | ready for a request; accepts and (with no wait states) accesses on the same edge
// S_WAIT | request captured, wait-state down-counter running; access on terminal count
// S_RESP | response held on the bus until the requester takes it
module sram_bank #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned SIZE_BYTES  = 98304,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  sram_bank_if.slave bus
);

  localparam int unsigned DEPTH   = SIZE_BYTES / 4;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS_LD   = 4'(WAIT_STATES);
  localparam logic [32:0] SIZE_33 = 33'(SIZE_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               err_q, err_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_error_q, resp_error_d;
  logic [31:0]        data_out_q, data_out_d;

  logic [31:0]        mem [DEPTH];

  // 33-bit offset: bit 32 set means the address lies below the base (borrow).
  logic [32:0]        off33;
  logic               req_hit;
  logic               req_err;

  logic               acc_en;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;
  logic [3:0]         acc_be;
  logic               acc_err;
  logic               mem_we;

  assign off33   = {1'b0, bus.address} - {1'b0, BASE_ADDR};
  assign req_hit = !off33[32] && (off33 < SIZE_33);
  assign req_err = !req_hit || (bus.address[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    data_out_d   = data_out_q;
    acc_en       = 1'b0;
    acc_wr       = wr_q;
    acc_idx      = idx_q;
    acc_wdata    = wdata_q;
    acc_be       = be_q;
    acc_err      = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.read_write;
          idx_d   = off33[IDX_W+1:2];
          wdata_d = bus.data_in;
          be_d    = bus.byte_enable;
          err_d   = req_err;
          cnt_d   = WS_LD;
          if (WAIT_STATES == 0) begin
            // No wait states: access straight from the bus on the accept edge.
            acc_en    = 1'b1;
            acc_wr    = bus.read_write;
            acc_idx   = off33[IDX_W+1:2];
            acc_wdata = bus.data_in;
            acc_be    = bus.byte_enable;
            acc_err   = req_err;
            state_d   = S_RESP;
          end else begin
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          acc_en  = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_error_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (acc_en) begin
      resp_valid_d = 1'b1;
      if (acc_err) begin
        resp_error_d = 1'b1;
        data_out_d   = 32'h0;
      end else if (!acc_wr) begin
        data_out_d   = mem[acc_idx];
      end
    end
  end

  assign mem_we = acc_en && acc_wr && !acc_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      data_out_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      data_out_q   <= data_out_d;
    end
  end

  // Array is deliberately outside reset; contents survive reset_n.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_sram_bank.sv
// Directed bench for sram_bank: one zero-wait instance and one three-wait instance.
module tb_sram_bank;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sram_bank_if bus0 ();
  sram_bank_if bus3 ();

  sram_bank #(.BASE_ADDR(32'h2000_0000), .SIZE_BYTES(98304), .WAIT_STATES(0)) u_bank0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  sram_bank #(.BASE_ADDR(32'h2000_0000), .SIZE_BYTES(98304), .WAIT_STATES(3)) u_bank3 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus3.slave)
  );

  logic        rv [2];
  logic        rw [2];
  logic        rr [2];
  logic [31:0] ad [2];
  logic [31:0] di [2];
  logic [3:0]  be [2];

  assign bus0.req_valid   = rv[0];
  assign bus0.read_write  = rw[0];
  assign bus0.resp_ready  = rr[0];
  assign bus0.address     = ad[0];
  assign bus0.data_in     = di[0];
  assign bus0.byte_enable = be[0];
  assign bus3.req_valid   = rv[1];
  assign bus3.read_write  = rw[1];
  assign bus3.resp_ready  = rr[1];
  assign bus3.address     = ad[1];
  assign bus3.data_in     = di[1];
  assign bus3.byte_enable = be[1];

  logic        o_rdy  [2];
  logic        o_vld  [2];
  logic        o_err  [2];
  logic [31:0] o_dout [2];

  assign o_rdy[0]  = bus0.req_ready;
  assign o_vld[0]  = bus0.resp_valid;
  assign o_err[0]  = bus0.resp_error;
  assign o_dout[0] = bus0.data_out;
  assign o_rdy[1]  = bus3.req_ready;
  assign o_vld[1]  = bus3.resp_valid;
  assign o_err[1]  = bus3.resp_error;
  assign o_dout[1] = bus3.data_out;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full transaction with resp_ready held high; w=0 is the zero-wait bank, w=1 the 3-wait bank.
  task automatic txn(input int w, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be_v, output logic [31:0] rd, output logic er,
                     output int lat, output int rdy_low);
    rv[w] = 1'b1; rw[w] = wr; ad[w] = addr; di[w] = wd; be[w] = be_v; rr[w] = 1'b1;
    lat = 0;
    rdy_low = 0;
    do begin
      step();
      rv[w] = 1'b0;
      lat++;
      if (!o_rdy[w]) rdy_low++;
    end while (!o_vld[w] && lat < 20);
    chk("resp_seen", 32'(o_vld[w]), 32'h1);
    rd = o_dout[w];
    er = o_err[w];
    step();
    chk("back_idle", 32'(o_rdy[w]), 32'h1);
  endtask

  task automatic chk_reset_vals(input int w);
    chk("rst_req_ready",  32'(o_rdy[w]), 32'h1);
    chk("rst_resp_valid", 32'(o_vld[w]), 32'h0);
    chk("rst_resp_error", 32'(o_err[w]), 32'h0);
    chk("rst_data_out",   o_dout[w],     32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rl;

    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; rr[i] = 1'b1;
      ad[i] = 32'h0; di[i] = 32'h0; be[i] = 4'h0;
    end

    // Reset values
    step(); step();
    chk_reset_vals(0);
    chk_reset_vals(1);
    reset_n = 1'b1;
    step();

    // Basic write then read, zero wait states
    txn(0, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat, rl);
    chk("wr_ok_err", 32'(er), 32'h0);
    chk("wr_ok_lat", 32'(lat), 32'd1);
    txn(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0, rd, er, lat, rl);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_err", 32'(er), 32'h0);
    chk("rd_lat", 32'(lat), 32'd1);

    // Write keeps previous read data on data_out
    txn(0, 1'b1, 32'h2000_0000, 32'h0BAD_F00D, 4'hF, rd, er, lat, rl);
    chk("wr_keeps_dout", rd, 32'hDEAD_BEEF);

    // Last word and byte-lane merge
    txn(0, 1'b1, 32'h2001_7FFC, 32'h1122_3344, 4'hF, rd, er, lat, rl);
    chk("last_wr_err", 32'(er), 32'h0);
    txn(0, 1'b1, 32'h2001_7FFC, 32'hAABB_CCDD, 4'b0101, rd, er, lat, rl);
    txn(0, 1'b0, 32'h2001_7FFC, 32'h0, 4'h0, rd, er, lat, rl);
    chk("be_merge", rd, 32'h11BB_33DD);
    chk("be_merge_err", 32'(er), 32'h0);

    // Zero byte-enable write is an OK no-op
    txn(0, 1'b1, 32'h2000_0010, 32'h0123_4567, 4'h0, rd, er, lat, rl);
    chk("be0_err", 32'(er), 32'h0);
    txn(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0, rd, er, lat, rl);
    chk("be0_nochange", rd, 32'hDEAD_BEEF);

    // Error responses: above range, below range, misaligned
    txn(0, 1'b0, 32'h2001_8000, 32'h0, 4'h0, rd, er, lat, rl);
    chk("oor_hi_err", 32'(er), 32'h1);
    chk("oor_hi_data", rd, 32'h0);
    txn(0, 1'b0, 32'h2000_0000, 32'h0, 4'h0, rd, er, lat, rl);
    txn(0, 1'b0, 32'h1FFF_FFFC, 32'h0, 4'h0, rd, er, lat, rl);
    chk("oor_lo_err", 32'(er), 32'h1);
    chk("oor_lo_data", rd, 32'h0);
    txn(0, 1'b0, 32'h2000_0002, 32'h0, 4'h0, rd, er, lat, rl);
    chk("misal_err", 32'(er), 32'h1);
    chk("misal_data", rd, 32'h0);
    txn(0, 1'b1, 32'h2000_0002, 32'hFFFF_FFFF, 4'hF, rd, er, lat, rl);
    chk("misal_wr_err", 32'(er), 32'h1);
    txn(0, 1'b1, 32'h2001_8000, 32'hFFFF_FFFF, 4'hF, rd, er, lat, rl);
    chk("oor_wr_err", 32'(er), 32'h1);
    txn(0, 1'b0, 32'h2000_0000, 32'h0, 4'h0, rd, er, lat, rl);
    chk("err_no_change", rd, 32'h0BAD_F00D);
    chk("err_no_change_err", 32'(er), 32'h0);

    // Three wait states
    txn(1, 1'b1, 32'h2000_0040, 32'hCAFE_0123, 4'hF, rd, er, lat, rl);
    chk("ws3_wr_lat", 32'(lat), 32'd4);
    txn(1, 1'b0, 32'h2000_0040, 32'h0, 4'h0, rd, er, lat, rl);
    chk("ws3_rd_data", rd, 32'hCAFE_0123);
    chk("ws3_rd_lat", 32'(lat), 32'd4);
    chk("ws3_rdy_low", 32'(rl), 32'd4);

    // Response held while resp_ready is low; inputs toggled meanwhile
    rr[0] = 1'b0; rv[0] = 1'b1; rw[0] = 1'b0; ad[0] = 32'h2000_0010; be[0] = 4'h0;
    step();
    rv[0] = 1'b0;
    chk("hold_vld0", 32'(o_vld[0]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      ad[0] = (i % 2 == 0) ? 32'h2001_8000 : 32'h2000_0000;
      di[0] = 32'h5A5A_0000 + 32'(i);
      rw[0] = ~rw[0];
      step();
      chk("hold_vld",  32'(o_vld[0]), 32'h1);
      chk("hold_data", o_dout[0],     32'hDEAD_BEEF);
      chk("hold_err",  32'(o_err[0]), 32'h0);
      chk("hold_rdy",  32'(o_rdy[0]), 32'h0);
    end
    rr[0] = 1'b1;
    step();
    chk("release_vld", 32'(o_vld[0]), 32'h0);
    chk("release_rdy", 32'(o_rdy[0]), 32'h1);

    // Reset during WAIT drops a pending write
    txn(1, 1'b1, 32'h2000_0020, 32'h0000_0000, 4'hF, rd, er, lat, rl);
    rv[1] = 1'b1; rw[1] = 1'b1; ad[1] = 32'h2000_0020; di[1] = 32'h5555_5555; be[1] = 4'hF;
    step();
    rv[1] = 1'b0;
    chk("pend_rdy", 32'(o_rdy[1]), 32'h0);
    step();
    reset_n = 1'b0;
    #1;
    chk_reset_vals(1);
    chk_reset_vals(0);
    step(); step();
    reset_n = 1'b1;
    step();
    txn(1, 1'b0, 32'h2000_0020, 32'h0, 4'h0, rd, er, lat, rl);
    chk("dropped_wr", rd, 32'h0000_0000);
    chk("dropped_wr_err", 32'(er), 32'h0);
    txn(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0, rd, er, lat, rl);
    chk("mem_survives_rst", rd, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
